// File: rtl/alarm_pkg.sv
// Shared types and helpers for the zoned alarm controller.
// State encodings are fixed because software reads them through the status port.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_SIREN    = 3'd4
  } alarm_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Loadable down-counter shared by the exit, entry and siren periods.
// Load wins over decrement; decrement saturates at zero so the count never wraps.
module delay_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/zoned_alarm_ctrl.sv
// Multi-zone alarm controller: exit/entry delays, instant zones, bounded siren
// with automatic re-arm, and sticky per-zone trip latches.
module zoned_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int                   NUM_ZONES    = 4,
  parameter int                   EXIT_DLY     = 16,
  parameter int                   ENTRY_DLY    = 16,
  parameter int                   SIREN_TIME   = 64,
  parameter logic [NUM_ZONES-1:0] INSTANT_MASK = '0,
  localparam int CNT_W = (max3(EXIT_DLY, ENTRY_DLY, SIREN_TIME) > 1) ?
                         $clog2(max3(EXIT_DLY, ENTRY_DLY, SIREN_TIME)) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [NUM_ZONES-1:0] zone_in,
  input  logic [NUM_ZONES-1:0] zone_en,
  output logic [2:0]           state,
  output logic                 alarm,
  output logic                 armed,
  output logic [NUM_ZONES-1:0] zone_latch,
  output logic [CNT_W-1:0]     remaining
);

  if (NUM_ZONES < 1 || NUM_ZONES > 8 || EXIT_DLY < 1 || ENTRY_DLY < 1 || SIREN_TIME < 1)
  begin : g_param_check
    $error("zoned_alarm_ctrl: delays must be >= 1 and NUM_ZONES in 1..8");
  end

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DLY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

  alarm_state_t         state_reg, state_next;
  logic                 alarm_reg;
  logic [NUM_ZONES-1:0] zone_latch_reg, zone_latch_next;
  logic [NUM_ZONES-1:0] trip, inst;
  logic                 tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]     tmr_load_val, tmr_cnt;

  // A disabled zone is invisible to every state, including the instant path.
  for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_trip
    assign trip[gi] = zone_in[gi] & zone_en[gi];
    assign inst[gi] = trip[gi] & INSTANT_MASK[gi];
  end

  delay_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_DISARMED;
      alarm_reg      <= 1'b0;
      zone_latch_reg <= '0;
    end else begin
      state_reg      <= state_next;
      alarm_reg      <= (state_next == ST_SIREN);
      zone_latch_reg <= zone_latch_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    zone_latch_next = zone_latch_reg;
    tmr_load        = 1'b0;
    tmr_load_val    = '0;
    tmr_dec         = 1'b0;

    if (disarm) begin
      // Loading zero keeps remaining at 0 in DISARMED.
      state_next = ST_DISARMED;
      tmr_load   = 1'b1;
    end else begin
      case (state_reg)
        ST_DISARMED: begin
          if (arm) begin
            state_next      = ST_EXIT;
            tmr_load        = 1'b1;
            tmr_load_val    = EXIT_LOAD;
            zone_latch_next = '0;
          end
        end
        ST_EXIT: begin
          if (tmr_zero) state_next = ST_ARMED;
          else          tmr_dec    = 1'b1;
        end
        ST_ARMED: begin
          zone_latch_next = zone_latch_reg | trip;
          if (inst != '0) begin
            state_next   = ST_SIREN;
            tmr_load     = 1'b1;
            tmr_load_val = SIREN_LOAD;
          end else if (trip != '0) begin
            state_next   = ST_ENTRY;
            tmr_load     = 1'b1;
            tmr_load_val = ENTRY_LOAD;
          end
        end
        ST_ENTRY: begin
          zone_latch_next = zone_latch_reg | trip;
          if ((inst != '0) || tmr_zero) begin
            state_next   = ST_SIREN;
            tmr_load     = 1'b1;
            tmr_load_val = SIREN_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_SIREN: begin
          zone_latch_next = zone_latch_reg | trip;
          if (tmr_zero) state_next = ST_ARMED;
          else          tmr_dec    = 1'b1;
        end
        default: begin
          state_next = ST_DISARMED;
          tmr_load   = 1'b1;
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign alarm      = alarm_reg;
  assign armed      = (state_reg == ST_ARMED) || (state_reg == ST_ENTRY) ||
                      (state_reg == ST_SIREN);
  assign zone_latch = zone_latch_reg;
  assign remaining  = tmr_cnt;

endmodule

// File: tb/tb_zoned_alarm_ctrl.sv
// Scenario-per-task bench for zoned_alarm_ctrl with a behavioural reference
// model used for the randomized run.
module tb_zoned_alarm_ctrl;

  localparam int NZ   = 4;
  localparam int EXD  = 4;
  localparam int END  = 3;
  localparam int SIRT = 5;
  localparam logic [NZ-1:0] IMASK = 4'b1000;
  localparam int CW   = $clog2(SIRT);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic [NZ-1:0] zone_in = '0;
  logic [NZ-1:0] zone_en = '1;
  logic [2:0]    state;
  logic          alarm;
  logic          armed;
  logic [NZ-1:0] zone_latch;
  logic [CW-1:0] remaining;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode numbers follow the documented state encodings.
  int            m_mode;
  int            m_left;
  logic [NZ-1:0] m_latch;

  zoned_alarm_ctrl #(
    .NUM_ZONES    (NZ),
    .EXIT_DLY     (EXD),
    .ENTRY_DLY    (END),
    .SIREN_TIME   (SIRT),
    .INSTANT_MASK (IMASK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .disarm     (disarm),
    .zone_in    (zone_in),
    .zone_en    (zone_en),
    .state      (state),
    .alarm      (alarm),
    .armed      (armed),
    .zone_latch (zone_latch),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode  = 0;
    m_left  = 0;
    m_latch = '0;
  endtask

  task automatic model_edge();
    logic [NZ-1:0] t, ins;
    t   = zone_in & zone_en;
    ins = t & IMASK;
    if (disarm) begin
      m_mode = 0;
      m_left = 0;
    end else if (m_mode == 0) begin
      if (arm) begin
        m_mode  = 1;
        m_left  = EXD - 1;
        m_latch = '0;
      end
    end else if (m_mode == 1) begin
      if (m_left == 0) m_mode = 2;
      else m_left--;
    end else begin
      m_latch = m_latch | t;
      if (m_mode == 2) begin
        if (ins != 0) begin m_mode = 4; m_left = SIRT - 1; end
        else if (t != 0) begin m_mode = 3; m_left = END - 1; end
      end else if (m_mode == 3) begin
        if (ins != 0 || m_left == 0) begin m_mode = 4; m_left = SIRT - 1; end
        else m_left--;
      end else begin
        if (m_left == 0) m_mode = 2;
        else m_left--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    arm     = 1'b0;
    disarm  = 1'b0;
    zone_in = '0;
    zone_en = '1;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_armed();
    do_reset();
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (EXD) step();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({state, alarm, armed, zone_latch, remaining} !== '0)
      $display("FAIL reset_values: state=%0d alarm=%0b armed=%0b latch=%b rem=%0d, want all 0",
               state, alarm, armed, zone_latch, remaining);
    else n_pass++;
    $display("reset: state=%0d alarm=%0b armed=%0b latch=%b rem=%0d", state, alarm, armed, zone_latch, remaining);
    do_reset();
  endtask

  task automatic test_arm_exit();
    do_reset();
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < EXD; i++) begin
      n_checks++;
      if (state !== 3'd1 || remaining !== CW'(EXD - 1 - i) || armed !== 1'b0)
        $display("FAIL exit_cycle%0d: state=%0d rem=%0d armed=%0b, want state=1 rem=%0d armed=0",
                 i, state, remaining, armed, EXD - 1 - i);
      else n_pass++;
      $display("exit cycle %0d: state=%0d rem=%0d", i, state, remaining);
      step();
    end
    n_checks++;
    if (state !== 3'd2 || armed !== 1'b1 || remaining !== '0)
      $display("FAIL exit_to_armed: state=%0d armed=%0b rem=%0d, want 2/1/0", state, armed, remaining);
    else n_pass++;
    $display("after exit: state=%0d armed=%0b", state, armed);
  endtask

  task automatic test_entry();
    go_armed();
    zone_in = 4'b0010;
    step();
    zone_in = '0;
    for (int i = 0; i < END; i++) begin
      n_checks++;
      if (state !== 3'd3 || alarm !== 1'b0)
        $display("FAIL entry_cycle%0d: state=%0d alarm=%0b, want 3/0", i, state, alarm);
      else n_pass++;
      $display("entry cycle %0d: state=%0d rem=%0d", i, state, remaining);
      step();
    end
    for (int i = 0; i < SIRT; i++) begin
      n_checks++;
      if (state !== 3'd4 || alarm !== 1'b1)
        $display("FAIL siren_cycle%0d: state=%0d alarm=%0b, want 4/1", i, state, alarm);
      else n_pass++;
      $display("siren cycle %0d: state=%0d alarm=%0b", i, state, alarm);
      step();
    end
    n_checks++;
    if (state !== 3'd2 || alarm !== 1'b0 || zone_latch !== 4'b0010)
      $display("FAIL rearm: state=%0d alarm=%0b latch=%b, want 2/0/0010", state, alarm, zone_latch);
    else n_pass++;
    $display("rearm: state=%0d latch=%b", state, zone_latch);
  endtask

  task automatic test_instant();
    go_armed();
    zone_in = 4'b0001;
    step();
    n_checks++;
    if (state !== 3'd3)
      $display("FAIL instant_entry: state=%0d, want 3", state);
    else n_pass++;
    zone_in = 4'b1000;
    step();
    zone_in = '0;
    n_checks++;
    if (state !== 3'd4 || alarm !== 1'b1 || zone_latch !== 4'b1001)
      $display("FAIL instant_siren: state=%0d alarm=%0b latch=%b, want 4/1/1001", state, alarm, zone_latch);
    else n_pass++;
    $display("instant: state=%0d latch=%b", state, zone_latch);
  endtask

  task automatic test_zone_en();
    go_armed();
    zone_en = 4'b1110;
    zone_in = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (state !== 3'd2 || zone_latch !== '0)
        $display("FAIL masked_zone%0d: state=%0d latch=%b, want 2/0000", i, state, zone_latch);
      else n_pass++;
      $display("masked zone cycle %0d: state=%0d latch=%b", i, state, zone_latch);
    end
    zone_in = '0;
    zone_en = '1;
  endtask

  task automatic test_arm_disarm();
    do_reset();
    arm    = 1'b1;
    disarm = 1'b1;
    step();
    arm    = 1'b0;
    disarm = 1'b0;
    n_checks++;
    if (state !== 3'd0 || remaining !== '0)
      $display("FAIL arm_disarm: state=%0d rem=%0d, want 0/0", state, remaining);
    else n_pass++;
    $display("arm+disarm: state=%0d", state);
  endtask

  task automatic test_disarm_siren();
    go_armed();
    zone_in = 4'b1000;
    step();
    zone_in = '0;
    step();
    n_checks++;
    if (state !== 3'd4)
      $display("FAIL siren_second: state=%0d, want 4", state);
    else n_pass++;
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    n_checks++;
    if (state !== 3'd0 || alarm !== 1'b0 || zone_latch !== 4'b1000 || remaining !== '0)
      $display("FAIL disarm_siren: state=%0d alarm=%0b latch=%b rem=%0d, want 0/0/1000/0",
               state, alarm, zone_latch, remaining);
    else n_pass++;
    $display("disarm in siren: state=%0d latch=%b", state, zone_latch);
  endtask

  task automatic test_async_reset();
    go_armed();
    zone_in = 4'b0010;
    step();
    zone_in = '0;
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({state, alarm, armed, zone_latch, remaining} !== '0)
      $display("FAIL async_reset: state=%0d alarm=%0b armed=%0b latch=%b rem=%0d, want all 0",
               state, alarm, armed, zone_latch, remaining);
    else n_pass++;
    $display("async reset mid-entry: state=%0d latch=%b", state, zone_latch);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exit_ignore();
    do_reset();
    arm = 1'b1;
    step();
    arm = 1'b0;
    zone_in = 4'b0100;
    repeat (EXD - 1) step();
    zone_in = '0;
    step();
    n_checks++;
    if (state !== 3'd2 || zone_latch !== '0)
      $display("FAIL exit_ignore: state=%0d latch=%b, want 2/0000", state, zone_latch);
    else n_pass++;
    $display("trip during exit: state=%0d latch=%b", state, zone_latch);
  endtask

  task automatic test_random();
    logic [NZ-1:0] z;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      arm    = ($urandom_range(0, 7) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      z = '0;
      for (int b = 0; b < NZ; b++) z[b] = ($urandom_range(0, 9) == 0);
      zone_in = z;
      zone_en = ($urandom_range(0, 5) == 0) ? NZ'($urandom) : '1;
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
      n_checks++;
      if (state !== 3'(m_mode) || remaining !== CW'(m_left) || zone_latch !== m_latch ||
          alarm !== (m_mode == 4) || armed !== (m_mode >= 2))
        $display("FAIL random_cycle%0d: state=%0d rem=%0d latch=%b alarm=%0b armed=%0b, want %0d/%0d/%b/%0b/%0b",
                 i, state, remaining, zone_latch, alarm, armed,
                 m_mode, m_left, m_latch, (m_mode == 4), (m_mode >= 2));
      else n_pass++;
      $display("random %0d: arm=%0b dis=%0b zin=%b zen=%b -> state=%0d rem=%0d latch=%b",
               i, arm, disarm, zone_in, zone_en, state, remaining, zone_latch);
    end
    arm     = 1'b0;
    disarm  = 1'b0;
    zone_in = '0;
    zone_en = '1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arm_exit();
    test_entry();
    test_instant();
    test_zone_en();
    test_arm_disarm();
    test_disarm_siren();
    test_async_reset();
    test_exit_ignore();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zoned_alarm_ctrl.md
# zoned_alarm_ctrl

Parametrised multi-zone security alarm controller; successor to the single-sensor alarm FSM. It adds N maskable sensor zones, exit and entry delay timers, instant zones that bypass the entry delay, and a bounded siren period with automatic re-arm. Per-zone trip latches are kept for readout. It sits between the synchronised sensor inputs and the siren driver and status outputs of the security chip.

## Interface
- NUM_ZONES, 4, number of sensor zones (1..8)
- EXIT_DLY, 16, cycles spent in EXIT after arming (>=1)
- ENTRY_DLY, 16, cycles spent in ENTRY before the siren (>=1)
- SIREN_TIME, 64, cycles the siren stays on (>=1)
- INSTANT_MASK, '0, NUM_ZONES bits; a set bit means the zone skips the entry delay
- CNT_W, $clog2(max(EXIT_DLY,ENTRY_DLY,SIREN_TIME)), derived localparam, timer width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- arm  in  1  arm request, level-sampled
- disarm  in  1  disarm request, level-sampled; highest priority
- zone_in  in  NUM_ZONES  sensor trip levels, already synchronous to clk
- zone_en  in  NUM_ZONES  zone enable; a 0 bit ignores that zone everywhere
- state  out  3  current FSM state
- alarm  out  1  siren drive, registered
- armed  out  1  high in ARMED, ENTRY and SIREN
- zone_latch  out  NUM_ZONES  sticky record of tripped zones
- remaining  out  CNT_W  current timer value; 0 outside timed states

## Operation
- States and encodings: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, SIREN=4. Encodings 5–7 are illegal and return to DISARMED on the next edge.
- Active trips: `trip = zone_in & zone_en`; `inst = trip & INSTANT_MASK`.
- `disarm`=1 in any state: next state is DISARMED and `remaining` becomes 0. It wins over `arm` and over any trip in the same cycle. `zone_latch` is kept.
- DISARMED: `arm` takes the FSM to EXIT, loads `remaining`=EXIT_DLY-1 and clears `zone_latch` to 0. Trips are ignored.
- EXIT: trips are ignored and not latched. When `remaining`==0, go to ARMED; otherwise decrement. `arm` has no effect.
- ARMED, checked in this order:
  - `inst`≠0: go to SIREN, load SIREN_TIME-1.
  - else `trip`≠0: go to ENTRY, load ENTRY_DLY-1.
  - In both cases `zone_latch |= trip`.
- ENTRY: `zone_latch |= trip` every cycle.
  - `inst`≠0: go to SIREN immediately, load SIREN_TIME-1.
  - else `remaining`==0: go to SIREN, load SIREN_TIME-1.
  - else decrement.
- SIREN: `zone_latch |= trip`. When `remaining`==0, go to ARMED (auto re-arm); otherwise decrement. A zone still tripped after re-arm triggers again from ARMED.
- Outputs:
  - `alarm` <= (next_state == SIREN), so `alarm` is high exactly in the cycles where `state`==SIREN.
  - `armed` is decoded from `state`.
- Timer: unsigned CNT_W-bit down-counter. It never wraps: load happens only on state entry, and decrement only while nonzero.

## Timing
- Reset values: `state`=DISARMED, `alarm`=0, `armed`=0, `zone_latch`=0, `remaining`=0.
- Reset is asynchronous and takes effect immediately, including mid-EXIT, mid-ENTRY and mid-SIREN.
- `arm` sampled at edge k gives `state`=EXIT after edge k and ARMED after edge k+EXIT_DLY.
- A trip sampled at edge k while ARMED gives ENTRY after edge k and SIREN after edge k+ENTRY_DLY. For an instant zone, SIREN follows after edge k.
- SIREN lasts exactly SIREN_TIME cycles, then ARMED.
- `disarm` takes effect on the next edge, with 1-cycle latency, from every state.
- Latching: a trip is recorded in `zone_latch` on the same edge it is sampled.

## Structure
- Package `alarm_pkg` holds:
  - the state enum `alarm_state_t` (3-bit) with the fixed encodings above;
  - the helper function `max3`, used for CNT_W.
- Sub-module `delay_timer`: loadable down-counter with parameter W and ports `load`, `load_val`, `dec`, `cnt`, `zero`.
- The FSM, trip masking and latches live in `zoned_alarm_ctrl`.
- Elaboration-time assertion: every delay is >=1 and NUM_ZONES <= 8.

## Test plan
Bench parameters: NUM_ZONES=4, EXIT_DLY=4, ENTRY_DLY=3, SIREN_TIME=5, INSTANT_MASK=4'b1000.

- Arm pulse at edge 0 -> `state`=1 for edges 0–3; `state`=2 and `armed`=1 from edge 4; `remaining` reads 3,2,1,0.
- From ARMED, `zone_in`=4'b0010 for 1 cycle at edge 10 -> ENTRY at edges 10–12; SIREN with `alarm`=1 at edges 13–17; ARMED at edge 18; `zone_latch`=4'b0010.
- From ARMED, `zone_in`=4'b0001 at edge 10 then 4'b1000 at edge 11 -> ENTRY at 10, SIREN at 11; `zone_latch`=4'b1001.
- `zone_en`=4'b1110 with `zone_in`=4'b0001 held in ARMED -> no transition; `zone_latch` stays 0.
- `arm` and `disarm` both high in DISARMED -> remains DISARMED. `disarm` at the 2nd SIREN cycle -> DISARMED next edge, `alarm`=0, `zone_latch` kept.
- `rst_n` low mid-ENTRY -> all outputs reset asynchronously. `zone_in`=4'b0100 during EXIT -> ignored; `zone_latch`=0.
